ins_fetch_queue: RTL and testbench

Parametrised next-generation instruction fetcher. It decouples i-cache fetch from dispatch through a circular instruction queue of 2^DEPTH_LOG entries. It resolves JAL targets locally, consults the branch predictor for all other instructions, and supports ROB-driven redirect with safe discard of an in-flight cache response. It sits between the i-cache and the dispatcher and replaces the single-entry fetch path.

---
 rtl/const_def.sv | 18 +
 rtl/ins_queue.sv | 59 +++++
 rtl/ins_fetch_queue.sv | 143 ++++++++++++++
 tb/tb_ins_fetch_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/const_def.sv
// Shared fetch definitions: JAL opcode, fetch FSM states and the J-type
// immediate decoder used by the fetcher to resolve direct jumps locally.
package const_def;

    localparam logic [6:0] JAL_TYPE = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Reassembles the scrambled J-immediate; result is 21 bits, bit 20 is the sign.
    function automatic logic [20:0] j_imm(input logic [31:12] inst_hi);
        return {inst_hi[31], inst_hi[19:12], inst_hi[20], inst_hi[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ins_queue.sv
// Circular FIFO of 2^DEPTH_LOG entries with clear, occupancy count and a
// combinational head read. Callers guarantee no push when full / pop when empty.
module ins_queue #(
    parameter int DEPTH_LOG = 3,
    parameter int WIDTH     = 65
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    input  logic                 clear,
    output logic [WIDTH-1:0]     head_data,
    output logic [DEPTH_LOG:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] head_q, head_d;
    logic [DEPTH_LOG-1:0] tail_q, tail_d;
    logic [DEPTH_LOG:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            count_d = count_q + (DEPTH_LOG+1)'(push) - (DEPTH_LOG+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; entries are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[tail_q] <= push_data;
    end

    assign head_data = mem[head_q];
    assign count     = count_q;

endmodule

// File: rtl/ins_fetch_queue.sv
// Instruction fetcher: one outstanding i-cache request, local JAL resolution,
// predictor-driven next pc, and ROB redirect with stale-response discard.
module ins_fetch_queue
    import const_def::*;
#(
    parameter int               DEPTH_LOG = 3,
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            out_jump,
    output logic [XLEN-1:0] predict_inst,
    output logic [XLEN-1:0] predict_pc,
    input  logic            suggest_jump,
    input  logic [XLEN-1:0] suggest_pc,
    input  logic            should_reset,
    input  logic [XLEN-1:0] reset_pc,
    output logic            fetch_enable,
    output logic [XLEN-1:0] cache_pc,
    input  logic            cache_valid,
    input  logic [XLEN-1:0] cache_inst
);

    localparam int                   DEPTH   = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG+1:0] DEPTH_V = (DEPTH_LOG+2)'(DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cache_pc_q, cache_pc_d;
    logic            fetch_enable_q, fetch_enable_d;

    logic [DEPTH_LOG:0]   q_count;
    logic [2*XLEN:0]      q_head;
    logic                 q_push, q_pop, q_clear, pop_req;
    logic [DEPTH_LOG+1:0] occ_after_pop, occ_after_push;
    logic [20:0]          imm;
    logic [XLEN-1:0]      next_pc;
    logic                 next_jump;

    assign out_valid = (q_count != '0);
    assign pop_req   = out_valid && out_ready;
    assign q_clear   = rdy && should_reset;
    assign q_pop     = rdy && !should_reset && pop_req;
    assign q_push    = rdy && !should_reset && (state_q == BUSY) && cache_valid;

    // Slot accounting: a request may issue only if its response is guaranteed a slot.
    assign occ_after_pop  = {1'b0, q_count} - (DEPTH_LOG+2)'(pop_req);
    assign occ_after_push = {1'b0, q_count} + (DEPTH_LOG+2)'(1) - (DEPTH_LOG+2)'(pop_req);

    assign imm = j_imm(cache_inst[31:12]);

    always_comb begin
        if (cache_inst[6:0] == JAL_TYPE) begin
            next_pc   = pc_q + {{(XLEN-21){imm[20]}}, imm};
            next_jump = 1'b1;
        end else begin
            next_pc   = suggest_pc;
            next_jump = suggest_jump;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        cache_pc_d     = cache_pc_q;
        fetch_enable_d = fetch_enable_q;
        if (rdy) begin
            fetch_enable_d = 1'b0;
            if (should_reset) begin
                pc_d = reset_pc;
                if (state_q == BUSY) state_d = cache_valid ? IDLE : DRAIN;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (occ_after_pop < DEPTH_V) begin
                            fetch_enable_d = 1'b1;
                            cache_pc_d     = pc_q;
                            state_d        = BUSY;
                        end
                    end
                    BUSY: begin
                        if (cache_valid) begin
                            pc_d = next_pc;
                            if (occ_after_push < DEPTH_V) begin
                                fetch_enable_d = 1'b1;
                                cache_pc_d     = next_pc;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                    DRAIN: begin
                        if (cache_valid) state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            cache_pc_q     <= RESET_PC;
            fetch_enable_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            cache_pc_q     <= cache_pc_d;
            fetch_enable_q <= fetch_enable_d;
        end
    end

    ins_queue #(
        .DEPTH_LOG (DEPTH_LOG),
        .WIDTH     (2*XLEN+1)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data ({cache_inst, pc_q, next_jump}),
        .pop       (q_pop),
        .clear     (q_clear),
        .head_data (q_head),
        .count     (q_count)
    );

    assign out_inst     = q_head[2*XLEN:XLEN+1];
    assign out_pc       = q_head[XLEN:1];
    assign out_jump     = q_head[0];
    assign predict_inst = cache_inst;
    assign predict_pc   = pc_q;
    assign fetch_enable = fetch_enable_q;
    assign cache_pc     = cache_pc_q;

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed bench for ins_fetch_queue: fill/full behaviour, JAL and predictor
// next-pc selection, redirect/drain, same-cycle redirect, rdy freeze, async reset.
module tb_ins_fetch_queue;

    localparam logic [31:0] ADDI    = 32'h0010_0093;
    localparam logic [31:0] JAL_P8  = 32'h0080_006F;
    localparam logic [31:0] JAL_M8  = 32'hFF9F_F06F;
    localparam logic [31:0] STALE   = 32'h1234_5013;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        out_valid, out_ready, out_jump;
    logic [31:0] out_inst, out_pc, predict_inst, predict_pc;
    logic        suggest_jump, should_reset, fetch_enable, cache_valid;
    logic [31:0] suggest_pc, reset_pc, cache_pc, cache_inst;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] req_pc;
        logic [31:0] inst;
        logic        sj;
        logic [31:0] spc;
        logic        exp_jump;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    ins_fetch_queue dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inst     (out_inst),
        .out_pc       (out_pc),
        .out_jump     (out_jump),
        .predict_inst (predict_inst),
        .predict_pc   (predict_pc),
        .suggest_jump (suggest_jump),
        .suggest_pc   (suggest_pc),
        .should_reset (should_reset),
        .reset_pc     (reset_pc),
        .fetch_enable (fetch_enable),
        .cache_pc     (cache_pc),
        .cache_valid  (cache_valid),
        .cache_inst   (cache_inst)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_req(input logic [31:0] exp_pc);
        int n;
        n = 0;
        while (fetch_enable !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        if (fetch_enable !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL req_timeout: no fetch_enable within 16 cycles, want request at %h", exp_pc);
        end else begin
            chk("req_pc", cache_pc, exp_pc);
            $display("request cache_pc=%h (expected %h)", cache_pc, exp_pc);
        end
    endtask

    // Answers the outstanding request two cycles after it was seen.
    task automatic respond(input logic [31:0] inst, input logic sj, input logic [31:0] spc);
        tick();
        chk("pulse_one_cycle", {31'b0, fetch_enable}, 32'd0);
        tick();
        cache_valid  = 1'b1;
        cache_inst   = inst;
        suggest_jump = sj;
        suggest_pc   = spc;
        tick();
        cache_valid  = 1'b0;
        $display("response inst=%h suggest_jump=%0b suggest_pc=%h", inst, sj, spc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{req_pc: 32'h80,  inst: ADDI,   sj: 1'b0, spc: 32'h100, exp_jump: 1'b0};
        tbl[1] = '{req_pc: 32'h100, inst: JAL_P8, sj: 1'b0, spc: 32'h500, exp_jump: 1'b1};
        tbl[2] = '{req_pc: 32'h108, inst: ADDI,   sj: 1'b0, spc: 32'h40,  exp_jump: 1'b0};
        tbl[3] = '{req_pc: 32'h40,  inst: ADDI,   sj: 1'b1, spc: 32'h200, exp_jump: 1'b1};
        tbl[4] = '{req_pc: 32'h200, inst: JAL_M8, sj: 1'b0, spc: 32'h600, exp_jump: 1'b1};

        rst = 1'b1; rdy = 1'b1; out_ready = 1'b0;
        suggest_jump = 1'b0; suggest_pc = '0; should_reset = 1'b0; reset_pc = '0;
        cache_valid = 1'b0; cache_inst = '0;
        tick();
        tick();
        chk("rst_fetch_enable", {31'b0, fetch_enable}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_cache_pc", cache_pc, 32'h0);
        chk("rst_predict_pc", predict_pc, 32'h0);
        rst = 1'b0;

        // Fill the queue with out_ready low: requests 0..0x1C, then no more.
        for (int i = 0; i < 8; i++) begin
            wait_req(32'(4 * i));
            respond(ADDI, 1'b0, 32'(4 * i + 4));
        end
        chk("full_out_valid", {31'b0, out_valid}, 32'd1);
        chk("full_head_pc", out_pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("full_no_fetch", {31'b0, fetch_enable}, 32'd0);
            tick();
        end

        // One pop on a full queue frees a slot and issues on the same edge.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_issue_fetch", {31'b0, fetch_enable}, 32'd1);
        chk("pop_issue_pc", cache_pc, 32'h20);
        chk("pop_head_pc", out_pc, 32'h4);
        respond(ADDI, 1'b0, 32'h24);
        for (int i = 0; i < 2; i++) begin
            chk("refull_no_fetch", {31'b0, fetch_enable}, 32'd0);
            tick();
        end

        // Drain all 8 entries; the first pop re-enables fetching at 0x24.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("drain_valid", {31'b0, out_valid}, 32'd1);
            chk("drain_pc", out_pc, 32'(4 * (k + 1)));
            chk("drain_inst", out_inst, ADDI);
            chk("drain_jump", {31'b0, out_jump}, 32'd0);
            tick();
            if (k == 0) begin
                chk("drain_issue_fetch", {31'b0, fetch_enable}, 32'd1);
                chk("drain_issue_pc", cache_pc, 32'h24);
            end
        end
        out_ready = 1'b0;
        chk("drained_empty", {31'b0, out_valid}, 32'd0);

        // Redirect while BUSY: stale response three cycles later is discarded.
        should_reset = 1'b1;
        reset_pc     = 32'h80;
        tick();
        should_reset = 1'b0;
        chk("redir_predict_pc", predict_pc, 32'h80);
        chk("redir_fetch", {31'b0, fetch_enable}, 32'd0);
        tick();
        chk("drain_wait_fetch", {31'b0, fetch_enable}, 32'd0);
        tick();
        chk("drain_wait_fetch2", {31'b0, fetch_enable}, 32'd0);
        cache_valid = 1'b1;
        cache_inst  = STALE;
        tick();
        cache_valid = 1'b0;
        chk("stale_not_pushed", {31'b0, out_valid}, 32'd0);
        chk("stale_no_fetch", {31'b0, fetch_enable}, 32'd0);
        $display("stale response %h discarded", STALE);

        // Next-pc selection vectors: JAL forward/backward and predictor paths.
        for (int v = 0; v < 5; v++) begin
            wait_req(tbl[v].req_pc);
            chk("predict_pc", predict_pc, tbl[v].req_pc);
            respond(tbl[v].inst, tbl[v].sj, tbl[v].spc);
        end
        wait_req(32'h1F8);

        out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            chk("entry_valid", {31'b0, out_valid}, 32'd1);
            chk("entry_pc", out_pc, tbl[v].req_pc);
            chk("entry_inst", out_inst, tbl[v].inst);
            chk("entry_jump", {31'b0, out_jump}, {31'b0, tbl[v].exp_jump});
            $display("pop pc=%h inst=%h jump=%0b", out_pc, out_inst, out_jump);
            tick();
        end
        out_ready = 1'b0;
        cache_inst = 32'hA5A5_5A5A;
        #1;
        chk("predict_inst", predict_inst, 32'hA5A5_5A5A);

        // Redirect coinciding with the response: dropped, back to IDLE.
        cache_valid  = 1'b1;
        cache_inst   = ADDI;
        should_reset = 1'b1;
        reset_pc     = 32'h300;
        tick();
        cache_valid  = 1'b0;
        should_reset = 1'b0;
        chk("same_cycle_no_push", {31'b0, out_valid}, 32'd0);
        chk("same_cycle_no_fetch", {31'b0, fetch_enable}, 32'd0);
        chk("same_cycle_pc", predict_pc, 32'h300);
        tick();
        chk("same_cycle_next_fetch", {31'b0, fetch_enable}, 32'd1);
        chk("same_cycle_next_pc", cache_pc, 32'h300);

        // rdy low freezes the request pulse.
        rdy = 1'b0;
        tick();
        chk("freeze_fetch", {31'b0, fetch_enable}, 32'd1);
        chk("freeze_pc", cache_pc, 32'h300);
        tick();
        chk("freeze_fetch2", {31'b0, fetch_enable}, 32'd1);
        rdy = 1'b1;
        tick();
        chk("unfreeze_fetch", {31'b0, fetch_enable}, 32'd0);
        cache_valid  = 1'b1;
        cache_inst   = ADDI;
        suggest_jump = 1'b1;
        suggest_pc   = 32'h400;
        tick();
        cache_valid  = 1'b0;
        chk("post_freeze_valid", {31'b0, out_valid}, 32'd1);
        chk("post_freeze_pc", out_pc, 32'h300);
        chk("post_freeze_jump", {31'b0, out_jump}, 32'd1);
        chk("post_freeze_next", cache_pc, 32'h400);
        chk("post_freeze_fetch", {31'b0, fetch_enable}, 32'd1);

        // Asynchronous reset mid-cycle, no clock edge needed.
        #2;
        rst = 1'b1;
        #1;
        chk("async_out_valid", {31'b0, out_valid}, 32'd0);
        chk("async_fetch", {31'b0, fetch_enable}, 32'd0);
        chk("async_cache_pc", cache_pc, 32'h0);
        chk("async_predict_pc", predict_pc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
